// File: rtl/fifo_pkg.sv
// Shared widths and lane-slice helpers for the fifo_bank sort FIFO.
// FIFO_ERR_EN enables the sticky overflow/underflow flags on every lane.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LOG2_DEPTH = 4;
  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_CNT_W      = DEF_LOG2_DEPTH + 1;
  localparam int DEF_DEPTH      = 2 ** DEF_LOG2_DEPTH;

`ifdef FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  function automatic int cnt_w(input int log2_depth);
    return log2_depth + 1;
  endfunction

  function automatic int depth(input int log2_depth);
    return 2 ** log2_depth;
  endfunction

endpackage

// File: rtl/fifo_bank_if.sv
// Bus bundle for the fifo_bank lanes: per-lane requests in, data and flags out.
// FIFO_ERR_EN adds err_clr / overflow / underflow.
interface fifo_bank_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LOG2_DEPTH = DEF_LOG2_DEPTH,
  parameter int NUM_CH     = DEF_NUM_CH
);

  logic [NUM_CH*DATA_WIDTH-1:0]     din;
  logic [NUM_CH-1:0]                wr_en;
  logic [NUM_CH-1:0]                rd_en;
  logic [NUM_CH*DATA_WIDTH-1:0]     dout;
  logic [NUM_CH*DATA_WIDTH-1:0]     dcmp;
  logic [NUM_CH-1:0]                empty;
  logic [NUM_CH-1:0]                full;
  logic [NUM_CH-1:0]                almost_full;
  logic [NUM_CH*(LOG2_DEPTH+1)-1:0] count;
`ifdef FIFO_ERR_EN
  logic [NUM_CH-1:0]                err_clr;
  logic [NUM_CH-1:0]                overflow;
  logic [NUM_CH-1:0]                underflow;

  modport master (
    output din, wr_en, rd_en, err_clr,
    input  dout, dcmp, empty, full, almost_full, count, overflow, underflow
  );

  modport slave (
    input  din, wr_en, rd_en, err_clr,
    output dout, dcmp, empty, full, almost_full, count, overflow, underflow
  );
`else
  modport master (
    output din, wr_en, rd_en,
    input  dout, dcmp, empty, full, almost_full, count
  );

  modport slave (
    input  din, wr_en, rd_en,
    output dout, dcmp, empty, full, almost_full, count
  );
`endif

endinterface

// File: rtl/fifo_lane.sv
// One FIFO lane: pointers, storage, occupancy, flags and (FIFO_ERR_EN) sticky
// overflow/underflow. Reads are 0-latency; no write-to-read bypass.
module fifo_lane
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int LOG2_DEPTH   = DEF_LOG2_DEPTH,
  parameter int AFULL_THRESH = (2 ** LOG2_DEPTH) - 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic                  i_wr_en,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic [DATA_WIDTH-1:0] o_dcmp,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_almost_full,
  output logic [LOG2_DEPTH:0]   o_count
`ifdef FIFO_ERR_EN
  ,
  input  logic                  i_err_clr,
  output logic                  o_overflow,
  output logic                  o_underflow
`endif
);

  localparam int DEPTH = depth(LOG2_DEPTH);
  localparam int CNT_W = cnt_w(LOG2_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [LOG2_DEPTH-1:0] r_wr_ptr;
  logic [LOG2_DEPTH-1:0] r_rd_ptr;
  logic [CNT_W-1:0]      r_cnt;

  logic w_empty;
  logic w_full;
  logic w_rd_acc;
  logic w_wr_acc;

  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == CNT_W'(DEPTH));
  assign w_rd_acc = i_rd_en & ~w_empty;
  // A full lane still takes a write when the same cycle pops a word.
  assign w_wr_acc = i_wr_en & (~w_full | w_rd_acc);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_rd_acc, w_wr_acc})
        2'b10:   r_cnt <= r_cnt - 1'b1;
        2'b01:   r_cnt <= r_cnt + 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage is not reset; only the reset-cycle write is suppressed.
  always_ff @(posedge clk) begin
    if (!reset && w_wr_acc) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout        = w_rd_acc ? r_mem[r_rd_ptr] : '0;
  assign o_dcmp        = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_empty       = w_empty;
  assign o_full        = w_full;
  assign o_almost_full = (int'(r_cnt) >= AFULL_THRESH);
  assign o_count       = r_cnt;

`ifdef FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  // Set has priority over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (i_wr_en & ~w_wr_acc) | (r_overflow  & ~i_err_clr);
      r_underflow <= (i_rd_en & w_empty)   | (r_underflow & ~i_err_clr);
    end
  end

  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
`endif

endmodule

// File: rtl/fifo_bank.sv
// NUM_CH independent sort-FIFO lanes on one clock; this level only slices the
// bus into lanes. FIFO_ERR_EN adds per-lane sticky error flags.
module fifo_bank
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int LOG2_DEPTH   = DEF_LOG2_DEPTH,
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int AFULL_THRESH = (2 ** LOG2_DEPTH) - 2
) (
  input  logic        clk,
  input  logic        reset,
  fifo_bank_if.slave  bus
);

  localparam int CNT_W = cnt_w(LOG2_DEPTH);

  logic [NUM_CH-1:0][DATA_WIDTH-1:0] w_dout;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] w_dcmp;
  logic [NUM_CH-1:0][CNT_W-1:0]      w_count;
  logic [NUM_CH-1:0]                 w_empty;
  logic [NUM_CH-1:0]                 w_full;
  logic [NUM_CH-1:0]                 w_almost_full;
`ifdef FIFO_ERR_EN
  logic [NUM_CH-1:0]                 w_overflow;
  logic [NUM_CH-1:0]                 w_underflow;
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
    fifo_lane #(
      .DATA_WIDTH   (DATA_WIDTH),
      .LOG2_DEPTH   (LOG2_DEPTH),
      .AFULL_THRESH (AFULL_THRESH)
    ) u_lane (
      .clk           (clk),
      .reset         (reset),
      .i_din         (bus.din[gi*DATA_WIDTH +: DATA_WIDTH]),
      .i_wr_en       (bus.wr_en[gi]),
      .i_rd_en       (bus.rd_en[gi]),
      .o_dout        (w_dout[gi]),
      .o_dcmp        (w_dcmp[gi]),
      .o_empty       (w_empty[gi]),
      .o_full        (w_full[gi]),
      .o_almost_full (w_almost_full[gi]),
      .o_count       (w_count[gi])
`ifdef FIFO_ERR_EN
      ,
      .i_err_clr     (bus.err_clr[gi]),
      .o_overflow    (w_overflow[gi]),
      .o_underflow   (w_underflow[gi])
`endif
    );
  end

  assign bus.dout        = w_dout;
  assign bus.dcmp        = w_dcmp;
  assign bus.count       = w_count;
  assign bus.empty       = w_empty;
  assign bus.full        = w_full;
  assign bus.almost_full = w_almost_full;
`ifdef FIFO_ERR_EN
  assign bus.overflow    = w_overflow;
  assign bus.underflow   = w_underflow;
`endif

endmodule

// File: tb/tb_fifo_bank.sv
// Directed self-checking bench for fifo_bank (4 lanes x 16 x 32b).
// Error-flag checks are compiled in when FIFO_ERR_EN is defined.
module tb_fifo_bank;
  import fifo_pkg::*;

  localparam int DW    = 32;
  localparam int L2D   = 4;
  localparam int NCH   = 4;
  localparam int CW    = L2D + 1;
  localparam int DEPTH = 16;
  localparam int AFT   = 14;

  logic clk = 1'b0;
  logic reset;

  fifo_bank_if #(.DATA_WIDTH(DW), .LOG2_DEPTH(L2D), .NUM_CH(NCH)) bus ();

  fifo_bank #(
    .DATA_WIDTH(DW), .LOG2_DEPTH(L2D), .NUM_CH(NCH), .AFULL_THRESH(AFT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] d;
    logic [31:0] exp_dout;
    logic [31:0] exp_dcmp;
    logic [4:0]  exp_cnt;
    bit          exp_empty;
  } vec_t;

  vec_t vt [9];
  logic [31:0] q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] dout_of(input int ch);
    return bus.dout[ch*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] dcmp_of(input int ch);
    return bus.dcmp[ch*DW +: DW];
  endfunction

  function automatic logic [CW-1:0] cnt_of(input int ch);
    return bus.count[ch*CW +: CW];
  endfunction

  task automatic set_lane(input int ch, input bit wr, input bit rd, input logic [DW-1:0] d);
    bus.wr_en[ch]        = wr;
    bus.rd_en[ch]        = rd;
    bus.din[ch*DW +: DW] = d;
  endtask

  task automatic idle();
    bus.wr_en = '0;
    bus.rd_en = '0;
    bus.din   = '0;
`ifdef FIFO_ERR_EN
    bus.err_clr = '0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    for (int ch = 0; ch < NCH; ch++) begin
      check($sformatf("rst_count%0d", ch), cnt_of(ch), 0);
      check($sformatf("rst_empty%0d", ch), bus.empty[ch], 1);
      check($sformatf("rst_full%0d", ch), bus.full[ch], 0);
      check($sformatf("rst_afull%0d", ch), bus.almost_full[ch], 0);
      check($sformatf("rst_dcmp%0d", ch), dcmp_of(ch), 0);
`ifdef FIFO_ERR_EN
      check($sformatf("rst_ovf%0d", ch), bus.overflow[ch], 0);
      check($sformatf("rst_unf%0d", ch), bus.underflow[ch], 0);
`endif
    end

    // lane0 basic order: 4 writes then 4 pops, values sampled before each edge
    vt[0] = '{1, 0, 32'h11, 32'h0,  32'h0,  5'd0, 1};
    vt[1] = '{1, 0, 32'h12, 32'h0,  32'h11, 5'd1, 0};
    vt[2] = '{1, 0, 32'h13, 32'h0,  32'h11, 5'd2, 0};
    vt[3] = '{1, 0, 32'h14, 32'h0,  32'h11, 5'd3, 0};
    vt[4] = '{0, 1, 32'h0,  32'h11, 32'h11, 5'd4, 0};
    vt[5] = '{0, 1, 32'h0,  32'h12, 32'h12, 5'd3, 0};
    vt[6] = '{0, 1, 32'h0,  32'h13, 32'h13, 5'd2, 0};
    vt[7] = '{0, 1, 32'h0,  32'h14, 32'h14, 5'd1, 0};
    vt[8] = '{0, 0, 32'h0,  32'h0,  32'h0,  5'd0, 1};
    for (int i = 0; i < 9; i++) begin
      set_lane(0, vt[i].wr, vt[i].rd, vt[i].d);
      #1;
      check($sformatf("t1_dout0[%0d]", i), dout_of(0), vt[i].exp_dout);
      check($sformatf("t1_dcmp0[%0d]", i), dcmp_of(0), vt[i].exp_dcmp);
      check($sformatf("t1_cnt0[%0d]", i), cnt_of(0), vt[i].exp_cnt);
      check($sformatf("t1_empty0[%0d]", i), bus.empty[0], vt[i].exp_empty);
      tick();
    end
    idle();
    #1;
    for (int ch = 1; ch < NCH; ch++)
      check($sformatf("t1_other_cnt%0d", ch), cnt_of(ch), 0);

    // lane1 fill to full, drop 17th write, drain
    for (int k = 0; k < DEPTH; k++) begin
      set_lane(1, 1, 0, 32'h100 + k);
      #1;
      check($sformatf("t2_cnt1[%0d]", k), cnt_of(1), k);
      check($sformatf("t2_afull1[%0d]", k), bus.almost_full[1], (k >= AFT));
      check($sformatf("t2_full1[%0d]", k), bus.full[1], 0);
      tick();
    end
    idle();
    #1;
    check("t2_full1", bus.full[1], 1);
    check("t2_cnt1_16", cnt_of(1), 16);
    check("t2_afull1_16", bus.almost_full[1], 1);
    set_lane(1, 1, 0, 32'hDEAD);
    tick();
    idle();
    #1;
    check("t2_cnt1_after_drop", cnt_of(1), 16);
    check("t2_dcmp1_after_drop", dcmp_of(1), 32'h100);
`ifdef FIFO_ERR_EN
    check("t2_ovf1", bus.overflow[1], 1);
`endif
    for (int k = 0; k < DEPTH; k++) begin
      set_lane(1, 0, 1, 0);
      #1;
      check($sformatf("t2_dout1[%0d]", k), dout_of(1), 32'h100 + k);
      tick();
    end
    idle();
    #1;
    check("t2_empty1", bus.empty[1], 1);
    check("t2_cnt1_end", cnt_of(1), 0);

    // lane2 full with simultaneous read+write
    for (int k = 0; k < DEPTH; k++) begin
      set_lane(2, 1, 0, 32'h200 + k);
      tick();
    end
    set_lane(2, 1, 1, 32'hAA);
    #1;
    check("t3_dout2_rw", dout_of(2), 32'h200);
    tick();
    idle();
    #1;
    check("t3_cnt2", cnt_of(2), 16);
    check("t3_full2", bus.full[2], 1);
`ifdef FIFO_ERR_EN
    check("t3_ovf2", bus.overflow[2], 0);
`endif
    for (int k = 0; k < DEPTH; k++) begin
      set_lane(2, 0, 1, 0);
      #1;
      check($sformatf("t3_dout2[%0d]", k), dout_of(2), (k < 15) ? 32'h201 + k : 32'hAA);
      tick();
    end
    idle();
    #1;
    check("t3_empty2", bus.empty[2], 1);

    // lane3 empty with simultaneous read+write: write only, no bypass
    set_lane(3, 1, 1, 32'h55);
    #1;
    check("t4_dout3_rw", dout_of(3), 0);
    check("t4_dcmp3_rw", dcmp_of(3), 0);
    tick();
    idle();
    #1;
    check("t4_cnt3", cnt_of(3), 1);
    check("t4_dcmp3", dcmp_of(3), 32'h55);
`ifdef FIFO_ERR_EN
    check("t4_unf3", bus.underflow[3], 1);
    check("t4_ovf3", bus.overflow[3], 0);
`endif
    set_lane(3, 0, 1, 0);
    #1;
    check("t4_dout3_pop", dout_of(3), 32'h55);
    tick();
    idle();
`ifdef FIFO_ERR_EN
    bus.err_clr[3] = 1'b1;
    bus.rd_en[3]   = 1'b1;
    tick();
    idle();
    #1;
    check("t4_unf3_set_wins", bus.underflow[3], 1);
    bus.err_clr[3] = 1'b1;
    tick();
    idle();
    #1;
    check("t4_unf3_cleared", bus.underflow[3], 0);
    check("t4_ovf1_sticky", bus.overflow[1], 1);
`endif
    #1;
    check("t4_empty3", bus.empty[3], 1);

    // lane0 interleaved traffic across >2 pointer wraps, queue model
    q.delete();
    for (int k = 0; k < 40; k++) begin
      bit rd;
      bit racc;
      bit wacc;
      logic [31:0] exp;
      rd   = (k % 4) != 0;
      racc = rd && (q.size() > 0);
      wacc = (q.size() < DEPTH) || racc;
      exp  = racc ? q[0] : 32'h0;
      set_lane(0, 1, rd, 32'h300 + k);
      #1;
      check($sformatf("t5_dout0[%0d]", k), dout_of(0), exp);
      check($sformatf("t5_cnt0[%0d]", k), cnt_of(0), q.size());
      if (cnt_of(0) > CW'(DEPTH)) check($sformatf("t5_cnt0_bound[%0d]", k), cnt_of(0), DEPTH);
      if (racc) void'(q.pop_front());
      if (wacc) q.push_back(32'h300 + k);
      tick();
    end
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      set_lane(0, 0, 1, 0);
      #1;
      check($sformatf("t5_drain0[%0d]", k), dout_of(0), q.pop_front());
      tick();
    end
    idle();
    #1;
    check("t5_drain_done", q.size(), 0);
    check("t5_empty0", bus.empty[0], 1);

    // reset mid-stream with a write in the reset cycle
    for (int k = 0; k < 5; k++) begin
      set_lane(0, 1, 0, 32'h400 + k);
      tick();
    end
    idle();
    #1;
    check("t6_cnt0_pre", cnt_of(0), 5);
    set_lane(0, 1, 0, 32'h77);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    #1;
    check("t6_cnt0", cnt_of(0), 0);
    check("t6_empty0", bus.empty[0], 1);
    check("t6_dcmp0", dcmp_of(0), 0);
    tick();
    #1;
    check("t6_cnt0_later", cnt_of(0), 0);
    set_lane(0, 0, 1, 0);
    #1;
    check("t6_dout0_rd_empty", dout_of(0), 0);
    tick();
    set_lane(0, 1, 0, 32'h88);
    tick();
    idle();
    #1;
    check("t6_dcmp0_new", dcmp_of(0), 32'h88);
    check("t6_cnt0_new", cnt_of(0), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_bank.md
Name: fifo_bank

Overview:
- Multi-channel synchronous FIFO bank for the parallel merge-sort datapath.
- Provides NUM_CH independent FIFO lanes on one clock. Each lane has a head peek (compare) port, full/empty/almost-full flags and an occupancy count.
- Successor to the single-lane sort FIFO. Adds full protection, a guarded read, a programmable almost-full level and per-lane occupancy.
- Sits between the presort stage and the merge comparator tree. The comparators read every lane's head concurrently.

Parameters:
- DATA_WIDTH, 32, bits per entry.
- LOG2_DEPTH, 4, lane depth = 2**LOG2_DEPTH entries.
- NUM_CH, 4, number of independent lanes (>=1).
- AFULL_THRESH, 2**LOG2_DEPTH-2, almost_full asserts when count >= this value.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  synchronous, active-high.
- din  input  NUM_CH*DATA_WIDTH  write data; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- wr_en  input  NUM_CH  per-lane write request.
- rd_en  input  NUM_CH  per-lane read (pop) request.
- dout  output  NUM_CH*DATA_WIDTH  popped data; combinational, zero unless the read is accepted.
- dcmp  output  NUM_CH*DATA_WIDTH  head-of-lane peek; combinational; zero when the lane is empty.
- empty  output  NUM_CH  lane count == 0.
- full  output  NUM_CH  lane count == 2**LOG2_DEPTH.
- almost_full  output  NUM_CH  lane count >= AFULL_THRESH.
- count  output  NUM_CH*(LOG2_DEPTH+1)  per-lane occupancy.

Behaviour:
- Lanes are fully independent. Everything below applies per lane i.
- State per lane:
  - wr_ptr and rd_ptr, each LOG2_DEPTH bits, wrapping modulo 2**LOG2_DEPTH.
  - cnt, LOG2_DEPTH+1 bits.
  - mem[2**LOG2_DEPTH], which is not reset.
- Accept rules:
  - rd_acc = rd_en & ~empty.
  - wr_acc = wr_en & (~full | rd_acc).
  - On a full lane, a simultaneous read and write are both accepted and count is unchanged.
  - On an empty lane, a simultaneous read and write accept only the write. There is no bypass; the data becomes visible at dcmp next cycle.
- Write: on wr_acc, mem[wr_ptr] <= din_i and wr_ptr increments.
- Read:
  - dout_i = rd_acc ? mem[rd_ptr] : 0, in the same cycle as rd_en (0-cycle latency).
  - rd_ptr increments at the clock edge.
- Write-to-visibility latency: 1 cycle. A word written at edge N appears on dcmp/dout after edge N when it is the head.
- Count update:
  - {rd_acc, wr_acc} = 10: cnt-1.
  - 01: cnt+1.
  - 00 or 11: hold.
- Flags are derived combinationally from cnt. Count can never exceed 2**LOG2_DEPTH or drop below 0.
- Rejected operations: a write to a full lane (without an accepted read) or a read from an empty lane is dropped. Pointers, count and memory are untouched, and dout is 0.
- Reset (any cycle, including mid-stream):
  - Pointers and cnt go to 0; empty=1, full=0, almost_full=(AFULL_THRESH==0), count=0.
  - dout=0 and dcmp=0 from the first cycle after reset.
  - Requests in the reset cycle are ignored.
  - Memory contents are unspecified after reset.
- Order: strict FIFO order per lane, with no reordering across pointer wrap-around.

Optional Feature:
- Macro: FIFO_ERR_EN.
- When defined:
  - Adds outputs overflow [NUM_CH] and underflow [NUM_CH], plus input err_clr [NUM_CH].
  - overflow_i sets on wr_en & ~wr_acc; underflow_i sets on rd_en & empty.
  - Both flags are sticky until err_clr_i or reset. If set and clear occur in the same cycle, set wins.
  - Reset value is 0.
- When undefined: these ports and their registers are absent. Drop behaviour is identical.

Decomposition:
- Shared package/header fifo_pkg:
  - Default widths.
  - Lane-slice helper localparams (CNT_W = LOG2_DEPTH+1, DEPTH = 2**LOG2_DEPTH).
  - The FIFO_ERR_EN guard.
- One sub-module, fifo_lane:
  - Single-lane pointers, memory, count, flags and optional error logic.
  - fifo_bank instantiates NUM_CH copies via generate and does only the bus slicing.

Test Plan:
- Reset, then write lane0 values 0x11..0x14 over 4 cycles, then pop 4 -> dout0 = 0x11,0x12,0x13,0x14 in order; count0 goes 4→0; empty0=1 at end; other lanes untouched.
- Fill lane1 with 16 writes (LOG2_DEPTH=4) -> full1=1 and count1=16; almost_full1 from count 14; a 17th write is dropped; pop 16 returns the original data in order; overflow1=1 if FIFO_ERR_EN.
- Full lane2 with simultaneous rd_en and wr_en=0xAA -> dout2 = oldest word; count2 stays 16; 0xAA pops last after 16 further reads.
- Empty lane3 with simultaneous rd_en and wr_en=0x55 -> dout3=0 in that cycle; count3=1; next cycle dcmp3=0x55; underflow3=1 if FIFO_ERR_EN.
- Run 40 write/read interleaved operations on lane0 for pointer wraparound (>2 wraps) -> scoreboard order matches; count never exceeds 16.
- Reset asserted with count0=5 and wr_en=1 -> next cycle count0=0, empty0=1, dcmp0=0; the reset-cycle write is lost.
